// File: rtl/gate_checker.sv
// Exhaustive truth-table checker for an external 1- or 2-input gate.
// Drives each input vector, lets it settle, samples dut_out and tallies mismatches.
module gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic             dut_out,
  output logic             drive_a,
  output logic             drive_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic             op_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

  state_t          state;
  logic [2:0]      op_reg;
  logic [1:0]      idx;
  logic [3:0]      cnt;

  logic             is_not;
  logic             expected;
  logic             sample;
  logic             mismatch;
  logic             last_vec;
  logic [1:0]       idx_next;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    is_not = (op_reg == 3'd0);
    case (op_reg)
      3'd0:    expected = ~drive_a;
      3'd1:    expected = drive_a & drive_b;
      3'd2:    expected = drive_a | drive_b;
      3'd3:    expected = drive_a ^ drive_b;
      3'd4:    expected = ~(drive_a & drive_b);
      3'd5:    expected = ~(drive_a | drive_b);
      default: expected = 1'b0;
    endcase
    sample   = (state == DRIVE) && (cnt == SETTLE_LIM);
    mismatch = sample && (dut_out != expected);
    // NOT only exercises a, so it steps over the b=1 indices
    last_vec = is_not ? (idx == 2'd2) : (idx == 2'd3);
    idx_next = is_not ? 2'(idx + 2'd2) : 2'(idx + 2'd1);
    err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_reg    <= 3'd0;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      drive_a   <= 1'b0;
      drive_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= 4'd0;
      op_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_reg    <= op_sel;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            drive_a   <= 1'b0;
            drive_b   <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            if (op_sel <= 3'd5) begin
              state  <= DRIVE;
              busy   <= 1'b1;
              op_err <= 1'b0;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              op_err <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (sample) begin
            cnt       <= 4'd0;
            err_count <= err_next;
            if (mismatch) fail_vec[idx] <= 1'b1;
            if (last_vec) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next == '0);
              drive_a <= 1'b0;
              drive_b <= 1'b0;
            end else begin
              idx     <= idx_next;
              drive_a <= idx_next[1];
              drive_b <= idx_next[0];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: emulates the external gate as a 4-entry truth table and
// predicts each run's verdict from the gate definitions.
module tb_gate_checker;
  localparam int S     = 2;
  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, dut_out;
  logic [2:0]       op_sel;
  logic             drive_a, drive_b, busy, done, pass, op_err;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;
  logic [3:0]       tt;

  gate_checker #(.SETTLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .dut_out(dut_out),
    .drive_a(drive_a), .drive_b(drive_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .op_err(op_err)
  );

  // the emulated gate answers from its truth table, indexed by {a,b}
  assign dut_out = tt[{drive_a, drive_b}];

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic logic ref_gate(input int op, input logic a, input logic b);
    case (op)
      0: return !a;
      1: return a && b;
      2: return a || b;
      3: return a != b;
      4: return !(a && b);
      5: return !(a || b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input int op, input logic [3:0] t, output logic [3:0] f,
                       output int e, output logic p, output logic oe, output int lat);
    int n;
    logic [1:0] v;
    f = 4'd0; e = 0; p = 1'b0; oe = 1'b0; lat = 0;
    if (op > 5) begin
      oe = 1'b1;
    end else begin
      n = (op == 0) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
        v = (op == 0) ? 2'(2 * k) : 2'(k);
        if (t[v] != ref_gate(op, v[1], v[0])) begin
          f[v] = 1'b1;
          if (e < (1 << ERR_W) - 1) e++;
        end
      end
      p   = (e == 0);
      lat = n * (S + 1);
    end
  endtask

  task automatic run_and_check(input string name, input logic [2:0] op, input logic [3:0] t,
                               input logic [3:0] xf, input int xe, input logic xp,
                               input logic xoe, input int xlat);
    int   k;
    logic busy_seen, bad_drive;
    tt = t; op_sel = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; busy_seen = 1'b0; bad_drive = 1'b0;
    while (!done && k < 300) begin
      if (busy) busy_seen = 1'b1;
      if (busy && op == 3'd0 && drive_b) bad_drive = 1'b1;
      if (!busy && (drive_a || drive_b)) bad_drive = 1'b1;
      start = busy ? 1'($urandom_range(0, 1)) : 1'b0;  // must be ignored mid-run
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check({name, "_latency"}, k, xlat);
    check({name, "_pass"}, pass, xp);
    check({name, "_err_count"}, err_count, xe);
    check({name, "_fail_vec"}, fail_vec, xf);
    check({name, "_op_err"}, op_err, xoe);
    check({name, "_busy_seen"}, busy_seen, (op <= 3'd5) ? 1 : 0);
    check({name, "_drive_rules"}, bad_drive, 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle_hold"}, {busy, done, pass, err_count, fail_vec, op_err},
          {1'b0, 1'b0, xp, ERR_W'(xe), xf, xoe});
    $display("run %s op=%0d tt=%b -> pass=%0d err=%0d fail_vec=%b op_err=%0d lat=%0d",
             name, op, t, pass, err_count, fail_vec, op_err, k);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] tt;
    logic [3:0] fail;
    int         err;
    logic       pass;
    logic       op_err;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] rf;
    int         re, rlat, k, last, ndone;
    logic       rp, roe, prev_done;
    logic [2:0] rop;
    logic [3:0] rtt;

    tbl[0] = '{3'd1, 4'b1000, 4'b0000, 0, 1'b1, 1'b0, 12};  // AND correct
    tbl[1] = '{3'd1, 4'b1111, 4'b0111, 3, 1'b0, 1'b0, 12};  // AND stuck-at-1
    tbl[2] = '{3'd0, 4'b0011, 4'b0000, 0, 1'b1, 1'b0, 6};   // NOT correct
    tbl[3] = '{3'd0, 4'b1111, 4'b0100, 1, 1'b0, 1'b0, 6};   // NOT stuck-at-1
    tbl[4] = '{3'd7, 4'b1000, 4'b0000, 0, 1'b0, 1'b1, 0};   // illegal op 7
    tbl[5] = '{3'd6, 4'b0000, 4'b0000, 0, 1'b0, 1'b1, 0};   // illegal op 6
    tbl[6] = '{3'd3, 4'b0110, 4'b0000, 0, 1'b1, 1'b0, 12};  // XOR correct
    tbl[7] = '{3'd5, 4'b0000, 4'b0001, 1, 1'b0, 1'b0, 12};  // NOR stuck-at-0
    tbl[8] = '{3'd2, 4'b0000, 4'b1110, 3, 1'b0, 1'b0, 12};  // OR stuck-at-0
    tbl[9] = '{3'd4, 4'b1000, 4'b1111, 4, 1'b0, 1'b0, 12};  // NAND wired as AND

    rst = 1'b1; start = 1'b0; op_sel = 3'd0; tt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {drive_a, drive_b, busy, done, pass, err_count, fail_vec, op_err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_and_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].tt, tbl[i].fail,
                    tbl[i].err, tbl[i].pass, tbl[i].op_err, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rtt = 4'($urandom_range(0, 15));
      model(rop, rtt, rf, re, rp, roe, rlat);
      run_and_check($sformatf("rnd%0d", i), rop, rtt, rf, re, rp, roe, rlat);
    end

    // reset mid-run: rst must act only at the clock edge
    tt = 4'b1000; op_sel = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_between_edges", busy, 1);
    @(posedge clk); #1;
    check("rst_midrun", {drive_a, drive_b, busy, done, pass, err_count, fail_vec, op_err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_and_check("after_rst", 3'd1, 4'b1000, 4'b0000, 0, 1'b1, 1'b0, 12);

    // start held high: back-to-back runs with no IDLE cycle
    tt = 4'b1000; op_sel = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    k = 0; last = -1; ndone = 0; prev_done = 1'b0;
    while (k < 45) begin
      if (done) begin
        if (last >= 0) check("b2b_period", k - last, 13);
        else check("b2b_first", k, 12);
        check("b2b_pass", {pass, err_count, fail_vec}, {1'b1, ERR_W'(0), 4'd0});
        last = k; ndone++;
      end else if (prev_done) begin
        check("b2b_cleared", {busy, pass}, 2'b10);
      end
      prev_done = done;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_final", {busy, pass}, 2'b01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: extra hold cycles per vector before sampling; legal range 0..15.
REQ-002 Parameter ERR_W, default 4: width of err_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a check run; sampled only in IDLE or DONE.
REQ-006 op_sel  input  3  gate under test: 0 NOT(a), 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR; 6-7 illegal.
REQ-007 dut_out  input  1  output of the external gate under test.
REQ-008 drive_a  output  1  registered stimulus to gate input a (input_value for NOT).
REQ-009 drive_b  output  1  registered stimulus to gate input b; always 0 for NOT.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 pass  output  1  run had zero mismatches; valid from done, held until next accepted start.
REQ-013 err_count  output  ERR_W  mismatch count, saturating.
REQ-014 fail_vec  output  4  bit {a,b} set when that vector mismatched.
REQ-015 op_err  output  1  accepted op_sel was illegal.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, DONE.
- IDLE -> DRIVE on start with legal op_sel.
- IDLE/DONE -> DONE on start with illegal op_sel.
- DRIVE -> DONE after the last sample.
- DONE -> IDLE after one cycle unless start is accepted.
REQ-017 On accepted start:
- latch op_sel;
- clear err_count, fail_vec, pass, op_err;
- drive vector 0 from the next cycle.
REQ-018 Vector order SHALL be:
- binary ops: {a,b} = 00, 01, 10, 11 (N=4);
- NOT: a = 0, then 1, with b = 0 (N=2, indices 0 and 2).
REQ-019 Each vector SHALL be held SETTLE_CYCLES+1 cycles; dut_out is sampled at the edge ending the last cycle, and the next vector is applied from that edge.
REQ-020 Expected value SHALL be computed from the latched op_sel and the current drive_a/drive_b; mismatch sets fail_vec[{a,b}] and increments err_count, saturating at 2^ERR_W-1.
REQ-021 With start accepted at edge E0:
- the last sample is at edge E0+N*(SETTLE_CYCLES+1);
- done=1 and pass=(err_count==0) in the following cycle.
REQ-022 Illegal op_sel SHALL give, in the cycle after acceptance:
- done=1, op_err=1, pass=0, err_count=0, fail_vec=0;
- no stimulus driven.
REQ-023 busy SHALL be 1 exactly while in DRIVE; start while busy is ignored.
REQ-024 drive_a and drive_b SHALL be 0 in IDLE and DONE.
REQ-025 start high in the DONE cycle SHALL be accepted, starting a new run with no IDLE cycle.
REQ-026 pass, err_count, fail_vec and op_err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst high at an edge SHALL force:
- state IDLE;
- drive_a, drive_b, busy, done, pass, op_err = 0;
- err_count = 0, fail_vec = 0;
- this applies in any state, including mid-run, and overrides start.
REQ-028 No output SHALL change on rst alone between clock edges.

Verification
REQ-029 Correct AND model on dut_out, op_sel=1, SETTLE_CYCLES=2, start at E0 -> done at cycle after E0+12, pass=1, err_count=0, fail_vec=0000.
REQ-030 dut_out stuck at 1, op_sel=1 -> fail_vec=0111, err_count=3, pass=0.
REQ-031 Correct NOT model, op_sel=0 -> done after E0+6, pass=1, drive_b always 0. Stuck-at-1 variant -> fail_vec=0100, err_count=1.
REQ-032 op_sel=7 -> done and op_err=1 in the next cycle, busy never 1, pass=0.
REQ-033 rst asserted at E0+5 during an AND run -> all outputs 0 after that edge. A new start then completes normally with pass=1.
REQ-034 start held high continuously with a correct AND model -> back-to-back runs, done every 13 cycles, results cleared at each acceptance.
